// File: rtl/vexriscv_bus_arbiter.sv
// vexriscv_bus_arbiter
//   Lets the VexRiscv iBus and dBus share one memory command/response port.
//   Commands are arbitrated round-robin. Only one read may be outstanding at a
//   time, and each read response is routed back to the bus that issued the read.
//
// Ports
//   clk, arst             clock; asynchronous active-high reset
//   ibus_cmd_*            fetch request in (valid, pc), ready out
//   ibus_rsp_*            fetch response out (valid, error, inst)
//   dbus_cmd_*            data request in (valid, wr, addr, data, size), ready out
//   dbus_rsp_*            data read response out (valid, error, data)
//   mem_cmd_*             forwarded command out, ready in
//   mem_rsp_*             memory read response in (valid, error, data)
//   err_unexp_rsp         sticky: a response arrived while no read was outstanding
module vexriscv_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              ibus_cmd_valid,
  output logic              ibus_cmd_ready,
  input  logic [ADDR_W-1:0] ibus_cmd_pc,
  output logic              ibus_rsp_valid,
  output logic              ibus_rsp_error,
  output logic [DATA_W-1:0] ibus_rsp_inst,
  input  logic              dbus_cmd_valid,
  output logic              dbus_cmd_ready,
  input  logic              dbus_cmd_wr,
  input  logic [ADDR_W-1:0] dbus_cmd_addr,
  input  logic [DATA_W-1:0] dbus_cmd_data,
  input  logic [1:0]        dbus_cmd_size,
  output logic              dbus_rsp_valid,
  output logic              dbus_rsp_error,
  output logic [DATA_W-1:0] dbus_rsp_data,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_wr,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [DATA_W-1:0] mem_cmd_data,
  output logic [1:0]        mem_cmd_size,
  input  logic              mem_rsp_valid,
  input  logic              mem_rsp_error,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              err_unexp_rsp
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HOLD     = 2'd1,
    S_WAIT_RSP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t r_state;
  owner_t r_hold_owner;
  owner_t r_rsp_owner;
  owner_t r_last_grant;
  logic   r_err_unexp_rsp;

  owner_t w_winner;
  logic   w_cmd_valid;
  logic   w_hs;

  // Grant selection. In HOLD the grant stays with the stalled requester so its
  // command is not swapped out from under the memory before the handshake.
  always_comb begin
    w_winner    = OWN_I;
    w_cmd_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ibus_cmd_valid && dbus_cmd_valid) begin
          w_winner = (r_last_grant == OWN_D) ? OWN_I : OWN_D;
        end else if (dbus_cmd_valid) begin
          w_winner = OWN_D;
        end else begin
          w_winner = OWN_I;
        end
        w_cmd_valid = ibus_cmd_valid | dbus_cmd_valid;
      end
      S_HOLD: begin
        w_winner    = r_hold_owner;
        w_cmd_valid = (r_hold_owner == OWN_D) ? dbus_cmd_valid : ibus_cmd_valid;
      end
      default: begin
        w_winner    = OWN_I;
        w_cmd_valid = 1'b0;
      end
    endcase
  end

  assign w_hs = w_cmd_valid & mem_cmd_ready;

  // Command mux: fetches are always full-word reads with no write data.
  always_comb begin
    mem_cmd_valid = w_cmd_valid;
    if (w_winner == OWN_D) begin
      mem_cmd_wr   = dbus_cmd_wr;
      mem_cmd_addr = dbus_cmd_addr;
      mem_cmd_data = dbus_cmd_data;
      mem_cmd_size = dbus_cmd_size;
    end else begin
      mem_cmd_wr   = 1'b0;
      mem_cmd_addr = ibus_cmd_pc;
      mem_cmd_data = '0;
      mem_cmd_size = 2'd2;
    end
  end

  assign ibus_cmd_ready = w_cmd_valid & (w_winner == OWN_I) & mem_cmd_ready;
  assign dbus_cmd_ready = w_cmd_valid & (w_winner == OWN_D) & mem_cmd_ready;

  // Response routing: only the read owner sees a valid, and only in WAIT_RSP.
  assign ibus_rsp_valid = (r_state == S_WAIT_RSP) & mem_rsp_valid & (r_rsp_owner == OWN_I);
  assign dbus_rsp_valid = (r_state == S_WAIT_RSP) & mem_rsp_valid & (r_rsp_owner == OWN_D);
  assign ibus_rsp_error = mem_rsp_error;
  assign ibus_rsp_inst  = mem_rsp_data;
  assign dbus_rsp_error = mem_rsp_error;
  assign dbus_rsp_data  = mem_rsp_data;

  assign err_unexp_rsp = r_err_unexp_rsp;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state         <= S_IDLE;
      r_hold_owner    <= OWN_I;
      r_rsp_owner     <= OWN_I;
      r_last_grant    <= OWN_D;
      r_err_unexp_rsp <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (mem_rsp_valid) begin
            r_err_unexp_rsp <= 1'b1;
          end
          if (w_hs) begin
            r_last_grant <= w_winner;
            if (!mem_cmd_wr) begin
              r_rsp_owner <= w_winner;
              r_state     <= S_WAIT_RSP;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (w_cmd_valid && r_state == S_IDLE) begin
            r_hold_owner <= w_winner;
            r_state      <= S_HOLD;
          end
        end
        S_WAIT_RSP: begin
          if (mem_rsp_valid) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vexriscv_bus_arbiter.sv
module tb_vexriscv_bus_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              arst;
  logic              ibus_cmd_valid;
  logic              ibus_cmd_ready;
  logic [ADDR_W-1:0] ibus_cmd_pc;
  logic              ibus_rsp_valid;
  logic              ibus_rsp_error;
  logic [DATA_W-1:0] ibus_rsp_inst;
  logic              dbus_cmd_valid;
  logic              dbus_cmd_ready;
  logic              dbus_cmd_wr;
  logic [ADDR_W-1:0] dbus_cmd_addr;
  logic [DATA_W-1:0] dbus_cmd_data;
  logic [1:0]        dbus_cmd_size;
  logic              dbus_rsp_valid;
  logic              dbus_rsp_error;
  logic [DATA_W-1:0] dbus_rsp_data;
  logic              mem_cmd_valid;
  logic              mem_cmd_ready;
  logic              mem_cmd_wr;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic [DATA_W-1:0] mem_cmd_data;
  logic [1:0]        mem_cmd_size;
  logic              mem_rsp_valid;
  logic              mem_rsp_error;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              err_unexp_rsp;

  int n_pass;
  int n_total;

  vexriscv_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .arst(arst),
    .ibus_cmd_valid(ibus_cmd_valid), .ibus_cmd_ready(ibus_cmd_ready), .ibus_cmd_pc(ibus_cmd_pc),
    .ibus_rsp_valid(ibus_rsp_valid), .ibus_rsp_error(ibus_rsp_error), .ibus_rsp_inst(ibus_rsp_inst),
    .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_ready(dbus_cmd_ready), .dbus_cmd_wr(dbus_cmd_wr),
    .dbus_cmd_addr(dbus_cmd_addr), .dbus_cmd_data(dbus_cmd_data), .dbus_cmd_size(dbus_cmd_size),
    .dbus_rsp_valid(dbus_rsp_valid), .dbus_rsp_error(dbus_rsp_error), .dbus_rsp_data(dbus_rsp_data),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_wr(mem_cmd_wr),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_data(mem_cmd_data), .mem_cmd_size(mem_cmd_size),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_error(mem_rsp_error), .mem_rsp_data(mem_rsp_data),
    .err_unexp_rsp(err_unexp_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle_inputs();
    ibus_cmd_valid = 1'b0; ibus_cmd_pc = '0;
    dbus_cmd_valid = 1'b0; dbus_cmd_wr = 1'b0; dbus_cmd_addr = '0;
    dbus_cmd_data = '0; dbus_cmd_size = 2'd0;
    mem_cmd_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_error = 1'b0; mem_rsp_data = '0;
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    idle_inputs();
    @(negedge clk);
    n_total++; if (mem_cmd_valid !== 1'b0) $display("FAIL rst_mem_valid: got %b want 0", mem_cmd_valid); else n_pass++;
    n_total++; if ({ibus_cmd_ready, dbus_cmd_ready} !== 2'b00) $display("FAIL rst_ready: got %b want 00", {ibus_cmd_ready, dbus_cmd_ready}); else n_pass++;
    n_total++; if ({ibus_rsp_valid, dbus_rsp_valid} !== 2'b00) $display("FAIL rst_rsp_valid: got %b want 00", {ibus_rsp_valid, dbus_rsp_valid}); else n_pass++;
    n_total++; if (err_unexp_rsp !== 1'b0) $display("FAIL rst_err: got %b want 0", err_unexp_rsp); else n_pass++;
    tick();
    arst = 1'b0;
    tick();
    @(negedge clk);
    n_total++; if ({mem_cmd_valid, ibus_cmd_ready, dbus_cmd_ready} !== 3'b000) $display("FAIL post_rst_idle: got %b want 000", {mem_cmd_valid, ibus_cmd_ready, dbus_cmd_ready}); else n_pass++;
  endtask

  task automatic test_single_fetch();
    do_reset();
    ibus_cmd_valid = 1'b1; ibus_cmd_pc = 32'h0000_0100; mem_cmd_ready = 1'b1;
    @(negedge clk);
    n_total++; if (mem_cmd_valid !== 1'b1) $display("FAIL fetch_mem_valid: got %b want 1", mem_cmd_valid); else n_pass++;
    n_total++; if (mem_cmd_addr !== 32'h100) $display("FAIL fetch_addr: got %h want 00000100", mem_cmd_addr); else n_pass++;
    n_total++; if ({mem_cmd_wr, mem_cmd_size} !== 3'b010) $display("FAIL fetch_wr_size: got %b want 010", {mem_cmd_wr, mem_cmd_size}); else n_pass++;
    n_total++; if (mem_cmd_data !== 32'h0) $display("FAIL fetch_data: got %h want 00000000", mem_cmd_data); else n_pass++;
    n_total++; if ({ibus_cmd_ready, dbus_cmd_ready} !== 2'b10) $display("FAIL fetch_ready: got %b want 10", {ibus_cmd_ready, dbus_cmd_ready}); else n_pass++;
    tick();
    ibus_cmd_valid = 1'b0;
    @(negedge clk);
    n_total++; if ({mem_cmd_valid, ibus_rsp_valid} !== 2'b00) $display("FAIL fetch_wait: got %b want 00", {mem_cmd_valid, ibus_rsp_valid}); else n_pass++;
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0013;
    @(negedge clk);
    n_total++; if ({ibus_rsp_valid, dbus_rsp_valid} !== 2'b10) $display("FAIL fetch_rsp_route: got %b want 10", {ibus_rsp_valid, dbus_rsp_valid}); else n_pass++;
    n_total++; if (ibus_rsp_inst !== 32'h13) $display("FAIL fetch_inst: got %h want 00000013", ibus_rsp_inst); else n_pass++;
    n_total++; if (ibus_rsp_error !== 1'b0) $display("FAIL fetch_err: got %b want 0", ibus_rsp_error); else n_pass++;
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    n_total++; if ({ibus_rsp_valid, err_unexp_rsp} !== 2'b00) $display("FAIL fetch_after: got %b want 00", {ibus_rsp_valid, err_unexp_rsp}); else n_pass++;
  endtask

  task automatic test_both_valid();
    do_reset();
    ibus_cmd_valid = 1'b1; ibus_cmd_pc = 32'h200;
    dbus_cmd_valid = 1'b1; dbus_cmd_wr = 1'b0; dbus_cmd_addr = 32'h8000; dbus_cmd_size = 2'd2;
    mem_cmd_ready = 1'b1;
    @(negedge clk);
    n_total++; if (mem_cmd_addr !== 32'h200) $display("FAIL both_first_addr: got %h want 00000200", mem_cmd_addr); else n_pass++;
    n_total++; if ({ibus_cmd_ready, dbus_cmd_ready} !== 2'b10) $display("FAIL both_first_ready: got %b want 10", {ibus_cmd_ready, dbus_cmd_ready}); else n_pass++;
    tick();
    ibus_cmd_valid = 1'b0;
    @(negedge clk);
    n_total++; if ({mem_cmd_valid, dbus_cmd_ready} !== 2'b00) $display("FAIL both_wait: got %b want 00", {mem_cmd_valid, dbus_cmd_ready}); else n_pass++;
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hAAAA_0001;
    @(negedge clk);
    n_total++; if ({ibus_rsp_valid, dbus_rsp_valid} !== 2'b10) $display("FAIL both_rsp_i: got %b want 10", {ibus_rsp_valid, dbus_rsp_valid}); else n_pass++;
    n_total++; if ({mem_cmd_valid, dbus_cmd_ready} !== 2'b00) $display("FAIL both_no_cmd_on_rsp: got %b want 00", {mem_cmd_valid, dbus_cmd_ready}); else n_pass++;
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    n_total++; if (mem_cmd_addr !== 32'h8000) $display("FAIL both_second_addr: got %h want 00008000", mem_cmd_addr); else n_pass++;
    n_total++; if ({mem_cmd_valid, dbus_cmd_ready, ibus_cmd_ready} !== 3'b110) $display("FAIL both_second_ready: got %b want 110", {mem_cmd_valid, dbus_cmd_ready, ibus_cmd_ready}); else n_pass++;
    tick();
    dbus_cmd_valid = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_55AA; mem_rsp_error = 1'b1;
    @(negedge clk);
    n_total++; if ({ibus_rsp_valid, dbus_rsp_valid} !== 2'b01) $display("FAIL both_rsp_d: got %b want 01", {ibus_rsp_valid, dbus_rsp_valid}); else n_pass++;
    n_total++; if ({dbus_rsp_error, dbus_rsp_data} !== {1'b1, 32'h0000_55AA}) $display("FAIL both_rsp_d_data: got %b %h want 1 000055aa", dbus_rsp_error, dbus_rsp_data); else n_pass++;
    tick();
    mem_rsp_valid = 1'b0; mem_rsp_error = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    // Setup fetch so that iBus holds the last grant and dBus wins the next tie.
    ibus_cmd_valid = 1'b1; ibus_cmd_pc = 32'h300; mem_cmd_ready = 1'b1;
    tick();
    ibus_cmd_valid = 1'b0; mem_rsp_valid = 1'b1;
    tick();
    mem_rsp_valid = 1'b0;
    ibus_cmd_valid = 1'b1; ibus_cmd_pc = 32'h400;
    dbus_cmd_valid = 1'b1; dbus_cmd_wr = 1'b1; dbus_cmd_addr = 32'h10;
    dbus_cmd_data = 32'hDEADBEEF; dbus_cmd_size = 2'd2;
    @(negedge clk);
    n_total++; if ({mem_cmd_wr, mem_cmd_addr, mem_cmd_data} !== {1'b1, 32'h10, 32'hDEADBEEF}) $display("FAIL b2b_w1: got %b %h %h want 1 00000010 deadbeef", mem_cmd_wr, mem_cmd_addr, mem_cmd_data); else n_pass++;
    n_total++; if ({dbus_cmd_ready, ibus_cmd_ready} !== 2'b10) $display("FAIL b2b_w1_ready: got %b want 10", {dbus_cmd_ready, ibus_cmd_ready}); else n_pass++;
    tick();
    dbus_cmd_addr = 32'h14;
    @(negedge clk);
    n_total++; if ({mem_cmd_wr, mem_cmd_addr, ibus_cmd_ready, dbus_cmd_ready} !== {1'b0, 32'h400, 2'b10}) $display("FAIL b2b_i1: got %b %h %b%b want 0 00000400 10", mem_cmd_wr, mem_cmd_addr, ibus_cmd_ready, dbus_cmd_ready); else n_pass++;
    tick();
    ibus_cmd_pc = 32'h404; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1111_2222;
    @(negedge clk);
    n_total++; if ({mem_cmd_valid, ibus_rsp_valid} !== 2'b01) $display("FAIL b2b_i1_rsp: got %b want 01", {mem_cmd_valid, ibus_rsp_valid}); else n_pass++;
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    n_total++; if ({mem_cmd_wr, mem_cmd_addr, dbus_cmd_ready} !== {1'b1, 32'h14, 1'b1}) $display("FAIL b2b_w2: got %b %h %b want 1 00000014 1", mem_cmd_wr, mem_cmd_addr, dbus_cmd_ready); else n_pass++;
    tick();
    dbus_cmd_addr = 32'h18;
    @(negedge clk);
    n_total++; if ({mem_cmd_addr, ibus_cmd_ready} !== {32'h404, 1'b1}) $display("FAIL b2b_i2: got %h %b want 00000404 1", mem_cmd_addr, ibus_cmd_ready); else n_pass++;
    tick();
    ibus_cmd_valid = 1'b0; mem_rsp_valid = 1'b1;
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    n_total++; if ({mem_cmd_addr, dbus_cmd_ready} !== {32'h18, 1'b1}) $display("FAIL b2b_w3: got %h %b want 00000018 1", mem_cmd_addr, dbus_cmd_ready); else n_pass++;
    // Writes alone go out one per cycle with no wait state.
    for (int k = 0; k < 2; k++) begin
      tick();
      dbus_cmd_addr = 32'h1C + 32'(4 * k);
      @(negedge clk);
      n_total++; if ({mem_cmd_valid, mem_cmd_addr, dbus_cmd_ready} !== {1'b1, 32'h1C + 32'(4 * k), 1'b1}) $display("FAIL b2b_wonly%0d: got %b %h %b want 1 %h 1", k, mem_cmd_valid, mem_cmd_addr, dbus_cmd_ready, 32'h1C + 32'(4 * k)); else n_pass++;
    end
    tick();
    dbus_cmd_valid = 1'b0; dbus_cmd_wr = 1'b0;
  endtask

  task automatic test_hold();
    do_reset();
    dbus_cmd_valid = 1'b1; dbus_cmd_wr = 1'b0; dbus_cmd_addr = 32'h900; dbus_cmd_size = 2'd1;
    mem_cmd_ready = 1'b0;
    @(negedge clk);
    n_total++; if ({mem_cmd_valid, mem_cmd_addr, dbus_cmd_ready} !== {1'b1, 32'h900, 1'b0}) $display("FAIL hold_c0: got %b %h %b want 1 00000900 0", mem_cmd_valid, mem_cmd_addr, dbus_cmd_ready); else n_pass++;
    tick();
    ibus_cmd_valid = 1'b1; ibus_cmd_pc = 32'hA00;
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      n_total++; if ({mem_cmd_addr, ibus_cmd_ready, dbus_cmd_ready} !== {32'h900, 2'b00}) $display("FAIL hold_c%0d: got %h %b%b want 00000900 00", k, mem_cmd_addr, ibus_cmd_ready, dbus_cmd_ready); else n_pass++;
      tick();
    end
    mem_cmd_ready = 1'b1;
    @(negedge clk);
    n_total++; if ({mem_cmd_addr, mem_cmd_size, ibus_cmd_ready, dbus_cmd_ready} !== {32'h900, 2'd1, 2'b01}) $display("FAIL hold_hs: got %h %0d %b%b want 00000900 1 01", mem_cmd_addr, mem_cmd_size, ibus_cmd_ready, dbus_cmd_ready); else n_pass++;
    tick();
    dbus_cmd_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0BAD_F00D;
    @(negedge clk);
    n_total++; if ({ibus_rsp_valid, dbus_rsp_valid, dbus_rsp_data} !== {2'b01, 32'h0BAD_F00D}) $display("FAIL hold_rsp: got %b%b %h want 01 0badf00d", ibus_rsp_valid, dbus_rsp_valid, dbus_rsp_data); else n_pass++;
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    n_total++; if ({mem_cmd_addr, ibus_cmd_ready} !== {32'hA00, 1'b1}) $display("FAIL hold_next_i: got %h %b want 00000a00 1", mem_cmd_addr, ibus_cmd_ready); else n_pass++;
    tick();
    ibus_cmd_valid = 1'b0; mem_rsp_valid = 1'b1;
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  task automatic test_unexp_rsp();
    do_reset();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
    @(negedge clk);
    n_total++; if ({ibus_rsp_valid, dbus_rsp_valid} !== 2'b00) $display("FAIL unexp_no_rsp: got %b want 00", {ibus_rsp_valid, dbus_rsp_valid}); else n_pass++;
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    n_total++; if (err_unexp_rsp !== 1'b1) $display("FAIL unexp_set: got %b want 1", err_unexp_rsp); else n_pass++;
    repeat (3) tick();
    @(negedge clk);
    n_total++; if (err_unexp_rsp !== 1'b1) $display("FAIL unexp_sticky: got %b want 1", err_unexp_rsp); else n_pass++;
    #1 arst = 1'b1;
    #1;
    n_total++; if (err_unexp_rsp !== 1'b0) $display("FAIL unexp_clear: got %b want 0", err_unexp_rsp); else n_pass++;
    tick();
    arst = 1'b0;
  endtask

  task automatic test_arst_wait();
    do_reset();
    dbus_cmd_valid = 1'b1; dbus_cmd_wr = 1'b0; dbus_cmd_addr = 32'h40; dbus_cmd_size = 2'd2;
    mem_cmd_ready = 1'b1;
    tick();
    dbus_cmd_valid = 1'b0;
    @(negedge clk);
    n_total++; if (mem_cmd_valid !== 1'b0) $display("FAIL arst_in_wait: got %b want 0", mem_cmd_valid); else n_pass++;
    #1 arst = 1'b1;
    #1;
    n_total++; if ({mem_cmd_valid, ibus_cmd_ready, dbus_cmd_ready, ibus_rsp_valid, dbus_rsp_valid} !== 5'b0) $display("FAIL arst_outputs: got %b want 00000", {mem_cmd_valid, ibus_cmd_ready, dbus_cmd_ready, ibus_rsp_valid, dbus_rsp_valid}); else n_pass++;
    tick();
    arst = 1'b0;
    dbus_cmd_valid = 1'b1; dbus_cmd_addr = 32'h44;
    @(negedge clk);
    n_total++; if ({mem_cmd_valid, mem_cmd_addr, dbus_cmd_ready} !== {1'b1, 32'h44, 1'b1}) $display("FAIL arst_new_read: got %b %h %b want 1 00000044 1", mem_cmd_valid, mem_cmd_addr, dbus_cmd_ready); else n_pass++;
    tick();
    dbus_cmd_valid = 1'b0; mem_rsp_valid = 1'b1;
    tick();
    mem_rsp_valid = 1'b0;
    // The abandoned read's response now arrives with nothing outstanding.
    mem_rsp_valid = 1'b1;
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    n_total++; if (err_unexp_rsp !== 1'b1) $display("FAIL arst_late_rsp: got %b want 1", err_unexp_rsp); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_single_fetch();
    test_both_valid();
    test_back_to_back();
    test_hold();
    test_unexp_rsp();
    test_arst_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
